// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte sender among NREQ requesters.
// Optional build macro UART_ARB_PRIO0_EN: requester 0 wins every arbitration it enters.
module uart_tx_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic [NREQ-1:0]           REQ,
    input  logic [NREQ*WIDTH-1:0]     REQ_DATA,
    output logic [NREQ-1:0]           ACK,
    output logic [WIDTH-1:0]          TX_DATA,
    output logic                      TX_FLAG,
    input  logic                      TX_BUSY,
    output logic [$clog2(NREQ)-1:0]   GRANT_ID,
    output logic                      ACTIVE,
    output logic                      DROP
);
    localparam int unsigned IDW     = $clog2(NREQ);
    localparam int unsigned CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, DRAIN, GAP} state_t;

    state_t           state, state_nx;
    logic [IDW-1:0]   last, win;
    logic             found, upd_last;
    logic [WIDTH-1:0] win_data;
    logic [CW-1:0]    cnt;
    logic             cnt_last, grant;
    logic [NREQ-1:0]  ack_nx;
    logic             flag_nx, drop_nx, active_nx;

    assign cnt_last = (cnt <= CW'(1));

    // Search last+1, last+2, ... with wrap; the first set request wins.
    always_comb begin
        int unsigned     idx;
        logic [NREQ-1:0] req_rot;
        win      = last;
        found    = 1'b0;
        idx      = 0;
        req_rot  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = 32'(last) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            req_rot = REQ >> idx;
            if (!found && req_rot[0]) begin
                win   = IDW'(idx);
                found = 1'b1;
            end
        end
`ifdef UART_ARB_PRIO0_EN
        // Requester 0 overrides the rotation and leaves the pointer untouched.
        if (REQ[0]) begin
            win   = '0;
            found = 1'b1;
        end
        upd_last = (win != '0);
`else
        upd_last = 1'b1;
`endif
        win_data = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (win == IDW'(j)) win_data = REQ_DATA[j*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (|REQ && !TX_BUSY) state_nx = LAUNCH;
            LAUNCH:    state_nx = WAIT_BUSY;
            WAIT_BUSY: begin
                if (TX_BUSY)       state_nx = DRAIN;
                else if (cnt_last) state_nx = GAP;
            end
            DRAIN:     if (!TX_BUSY) state_nx = GAP;
            GAP:       if (cnt_last) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        grant     = (state == IDLE) && (state_nx == LAUNCH);
        ack_nx    = grant ? (NREQ'(1) << win) : '0;
        flag_nx   = (state == LAUNCH);
        drop_nx   = (state == WAIT_BUSY) && (state_nx == GAP);
        active_nx = (state_nx != IDLE);
    end

    // Timeout is loaded with one less than the limit so DROP lands TIMEOUT_CYCLES after LAUNCH.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ACK      <= '0;
            TX_FLAG  <= 1'b0;
            DROP     <= 1'b0;
            ACTIVE   <= 1'b0;
            TX_DATA  <= '0;
            GRANT_ID <= '0;
            last     <= IDW'(NREQ - 1);
            cnt      <= '0;
        end else begin
            ACK     <= ack_nx;
            TX_FLAG <= flag_nx;
            DROP    <= drop_nx;
            ACTIVE  <= active_nx;
            if (grant) begin
                TX_DATA  <= win_data;
                GRANT_ID <= win;
                if (upd_last) last <= win;
            end
            if (state == LAUNCH)
                cnt <= CW'(TIMEOUT_CYCLES - 1);
            else if (state_nx == GAP && state != GAP)
                cnt <= CW'(GAP_CYCLES);
            else if ((state == WAIT_BUSY || state == GAP) && cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple sender model (busy 3 cycles after flag, 10 long).
module tb_uart_tx_arbiter;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned GAP   = 16;
    localparam int unsigned TO    = 8;

    logic                  CLK = 1'b0;
    logic                  RESET_N;
    logic [NREQ-1:0]       REQ;
    logic [NREQ*WIDTH-1:0] REQ_DATA;
    logic [NREQ-1:0]       ACK;
    logic [WIDTH-1:0]      TX_DATA;
    logic                  TX_FLAG;
    logic                  TX_BUSY;
    logic [1:0]            GRANT_ID;
    logic                  ACTIVE;
    logic                  DROP;

    logic sender_busy, force_busy, sender_en;
    int   n_vec, n_err;

    assign TX_BUSY = sender_busy | force_busy;

    uart_tx_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ), .REQ_DATA(REQ_DATA),
        .ACK(ACK), .TX_DATA(TX_DATA), .TX_FLAG(TX_FLAG), .TX_BUSY(TX_BUSY),
        .GRANT_ID(GRANT_ID), .ACTIVE(ACTIVE), .DROP(DROP)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        tick(2);
        RESET_N = 1'b1;
    endtask

    task automatic wait_ack(output int n, output int idle_at);
        n = 0;
        idle_at = 0;
        do begin
            @(negedge CLK);
            n++;
            if (!ACTIVE && idle_at == 0) idle_at = n;
        end while (ACK == '0 && n < 200);
        check("ack_seen", 32'(ACK != '0), 32'd1);
    endtask

    task automatic wait_idle(output int n, output int acks);
        n = 0;
        acks = 0;
        while (ACTIVE && n < 200) begin
            @(negedge CLK);
            n++;
            if (ACK != '0) acks++;
        end
        check("idle_reached", 32'(ACTIVE), 32'd0);
    endtask

    initial begin
        sender_busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (TX_FLAG && sender_en) begin
                repeat (3) @(negedge CLK);
                sender_busy = 1'b1;
                repeat (10) @(negedge CLK);
                sender_busy = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, m;
        n_vec = 0;
        n_err = 0;
        REQ = '0;
        REQ_DATA = '0;
        force_busy = 1'b0;
        sender_en = 1'b1;
        RESET_N = 1'b0;

        // reset values
        tick(2);
        check("rst_ack", 32'(ACK), 32'h0);
        check("rst_tx_data", 32'(TX_DATA), 32'h0);
        check("rst_tx_flag", 32'(TX_FLAG), 32'h0);
        check("rst_grant_id", 32'(GRANT_ID), 32'h0);
        check("rst_active", 32'(ACTIVE), 32'h0);
        check("rst_drop", 32'(DROP), 32'h0);

        // single request, latency and gap
        RESET_N = 1'b1;
        REQ = 4'b0001;
        REQ_DATA = {8'h00, 8'h00, 8'h00, 8'hA5};
        tick(1);
        check("t1_ack", 32'(ACK), 32'h1);
        check("t1_tx_data", 32'(TX_DATA), 32'hA5);
        check("t1_grant_id", 32'(GRANT_ID), 32'h0);
        check("t1_flag_in_ack_cycle", 32'(TX_FLAG), 32'h0);
        check("t1_active", 32'(ACTIVE), 32'h1);
        REQ = '0;
        tick(1);
        check("t1_flag", 32'(TX_FLAG), 32'h1);
        check("t1_ack_cleared", 32'(ACK), 32'h0);
        tick(1);
        check("t1_flag_one_cycle", 32'(TX_FLAG), 32'h0);
        REQ = 4'b0001;
        REQ_DATA = {8'h00, 8'h00, 8'h00, 8'h5A};
        tick(1);
        check("t1_tx_data_hold", 32'(TX_DATA), 32'hA5);
        wait_ack(n, m);
        check("t1_next_ack_latency", 32'(n), 32'd29);
        check("t1_idle_after_gap", 32'(m), 32'd28);
        check("t1_second_data", 32'(TX_DATA), 32'h5A);
        REQ = '0;
        wait_idle(n, m);

        // all four requesting: rotation 0,1,2,3,0
        do_reset();
        REQ_DATA = {8'h13, 8'h12, 8'h11, 8'h10};
        REQ = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(n, m);
            check("rr_ack", 32'(ACK), 32'(1) << (i % 4));
            check("rr_tx_data", 32'(TX_DATA), 32'h10 + 32'(i % 4));
            check("rr_grant_id", 32'(GRANT_ID), 32'(i % 4));
            if (i == 1) check("rr_byte_spacing", 32'(n), 32'd32);
        end
        REQ = '0;
        wait_idle(n, m);

        // wrap from pointer 2 past 3 to 0
        do_reset();
        REQ = 4'b0100;
        wait_ack(n, m);
        check("wrap_first", 32'(GRANT_ID), 32'd2);
        REQ = 4'b0101;
        wait_ack(n, m);
        check("wrap_to_0", 32'(GRANT_ID), 32'd0);
        wait_ack(n, m);
`ifdef UART_ARB_PRIO0_EN
        check("prio0_again", 32'(GRANT_ID), 32'd0);
`else
        check("rr_after_0", 32'(GRANT_ID), 32'd2);
`endif
        REQ = '0;
        wait_idle(n, m);

        // sender never raises busy
        sender_en = 1'b0;
        REQ = 4'b0010;
        wait_ack(n, m);
        REQ = '0;
        check("drop_grant_id", 32'(GRANT_ID), 32'd1);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (n == 1) check("drop_flag", 32'(TX_FLAG), 32'h1);
        end while (!DROP && n < 50);
        check("drop_delay", 32'(n), 32'(TO));
        tick(1);
        check("drop_one_cycle", 32'(DROP), 32'h0);
        wait_idle(n, m);
        check("drop_gap_len", 32'(n), 32'd15);
        check("drop_no_reack", 32'(m), 32'd0);
        sender_en = 1'b1;

        // asynchronous reset during DRAIN
        REQ = 4'b0001;
        REQ_DATA = {8'h13, 8'h12, 8'h11, 8'hC3};
        wait_ack(n, m);
        REQ = '0;
        check("drain_tx_data", 32'(TX_DATA), 32'hC3);
        tick(6);
        #2 RESET_N = 1'b0;
        #1;
        check("arst_active", 32'(ACTIVE), 32'h0);
        check("arst_tx_data", 32'(TX_DATA), 32'h0);
        check("arst_ack", 32'(ACK), 32'h0);
        tick(2);
        RESET_N = 1'b1;
        REQ = 4'b0010;
        tick(1);
        check("release_no_ack", 32'(ACK), 32'h0);
        check("release_no_flag", 32'(TX_FLAG), 32'h0);
        wait_ack(n, m);
        check("release_ack", 32'(ACK), 32'h2);
        check("release_grant_id", 32'(GRANT_ID), 32'd1);
        REQ = '0;
        wait_idle(n, m);

        // busy held high in IDLE blocks grants
        force_busy = 1'b1;
        REQ = 4'b0001;
        m = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (ACK != '0 || TX_FLAG) m++;
        end
        check("busy_blocks_grant", 32'(m), 32'd0);
        force_busy = 1'b0;
        wait_ack(n, m);
        check("busy_release_latency", 32'(n), 32'd1);
        check("busy_release_ack", 32'(ACK), 32'h1);
        REQ = '0;
        wait_idle(n, m);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
